// File: rtl/pixel_command_decoder_if.sv
// Command-byte and pending-write FIFO signals of the pixel command decoder.
// master = decoder side, slave = host / FIFO side.
interface pixel_command_decoder_if;
  logic [7:0]  commandByte;
  logic        commandValid;
  logic        commandReady;
  logic [24:0] pendingWriteQueueWriteBus;
  logic        pendingWriteQueueWriteRequest;
  logic        pendingWriteQueueWriteFull;
  logic        busy;
  logic        badOpcode;

  modport master (
    input  commandByte, commandValid, pendingWriteQueueWriteFull,
    output commandReady, pendingWriteQueueWriteBus, pendingWriteQueueWriteRequest,
           busy, badOpcode
  );

  modport slave (
    output commandByte, commandValid, pendingWriteQueueWriteFull,
    input  commandReady, pendingWriteQueueWriteBus, pendingWriteQueueWriteRequest,
           busy, badOpcode
  );
endinterface

// File: rtl/pixel_command_decoder.sv
// Decodes host drawing commands into {y, x, colour} pending-write FIFO entries.
// Optional PIXEL_COMMAND_CLIP_EN drops entries whose cursor lies off-screen.
module pixel_command_decoder #(
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 240
) (
  input  logic                   clock,
  input  logic                   reset,
  pixel_command_decoder_if.master pcd
);
  localparam logic [8:0] XMAX = 9'(SCREEN_WIDTH - 1);
  localparam logic [7:0] YMAX = 8'(SCREEN_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, ARG, WRITE, FILL} state_t;

  state_t      state_q;
  logic [2:0]  op_q;
  logic [1:0]  argIdx_q;
  logic [7:0]  argLo_q;
  logic [8:0]  curX_q;
  logic [7:0]  curY_q;
  logic [15:0] fillCnt_q;
  logic [24:0] bus_q;
  logic        badOp_q;
  logic        rdy_q;

  logic       active, clipped, step, accept;
  logic [8:0] nextX;
  logic [7:0] nextY;

  always_comb begin
    active = (state_q == WRITE) || (state_q == FILL);
`ifdef PIXEL_COMMAND_CLIP_EN
    clipped = active && ((bus_q[16:8] > XMAX) || (bus_q[24:17] > YMAX));
`else
    clipped = 1'b0;
`endif
    // Clipped pixels retire one per cycle regardless of FIFO back-pressure
    step   = active && (clipped || !pcd.pendingWriteQueueWriteFull);
    accept = pcd.commandValid && pcd.commandReady;
    if (curX_q >= XMAX) begin
      nextX = 9'd0;
      nextY = (curY_q >= YMAX) ? 8'd0 : curY_q + 8'd1;
    end else begin
      nextX = curX_q + 9'd1;
      nextY = curY_q;
    end
  end

  assign pcd.commandReady = rdy_q && ((state_q == IDLE) || (state_q == ARG));
  assign pcd.pendingWriteQueueWriteRequest = active && !pcd.pendingWriteQueueWriteFull && !clipped;
  assign pcd.pendingWriteQueueWriteBus = bus_q;
  assign pcd.busy      = active;
  assign pcd.badOpcode = badOp_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_q      <= 3'd0;
      argIdx_q  <= 2'd0;
      argLo_q   <= 8'd0;
      curX_q    <= 9'd0;
      curY_q    <= 8'd0;
      fillCnt_q <= 16'd0;
      bus_q     <= 25'd0;
      badOp_q   <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      case (state_q)
        IDLE: if (accept) begin
          argIdx_q <= 2'd0;
          op_q     <= pcd.commandByte[2:0];
          case (pcd.commandByte)
            8'h00: ;
            8'h01, 8'h02, 8'h03, 8'h04: state_q <= ARG;
            default: badOp_q <= 1'b1;
          endcase
        end
        ARG: if (accept) begin
          argIdx_q <= argIdx_q + 2'd1;
          case (op_q)
            3'd1: if (argIdx_q == 2'd0) argLo_q <= pcd.commandByte;
                  else begin
                    curX_q  <= {pcd.commandByte[0], argLo_q};
                    state_q <= IDLE;
                  end
            3'd2: begin
              curY_q  <= pcd.commandByte;
              state_q <= IDLE;
            end
            3'd3: begin
              bus_q   <= {curY_q, curX_q, pcd.commandByte};
              state_q <= WRITE;
            end
            3'd4: if (argIdx_q == 2'd0) fillCnt_q[7:0] <= pcd.commandByte;
                  else if (argIdx_q == 2'd1) fillCnt_q[15:8] <= pcd.commandByte;
                  else if (fillCnt_q == 16'd0) state_q <= IDLE;
                  else begin
                    bus_q   <= {curY_q, curX_q, pcd.commandByte};
                    state_q <= FILL;
                  end
            default: state_q <= IDLE;
          endcase
        end
        WRITE: if (step) begin
          curX_q  <= nextX;
          curY_q  <= nextY;
          state_q <= IDLE;
        end
        FILL: if (step) begin
          curX_q    <= nextX;
          curY_q    <= nextY;
          fillCnt_q <= fillCnt_q - 16'd1;
          bus_q     <= {nextY, nextX, bus_q[7:0]};
          if (fillCnt_q == 16'd1) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_command_decoder.sv
// Directed self-checking bench for pixel_command_decoder.
module tb_pixel_command_decoder;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pixel_command_decoder_if pcd();
  pixel_command_decoder dut (.clock(clock), .reset(reset), .pcd(pcd));

  int checks = 0;
  int fails  = 0;
  int cyc = 0;
  int busyCycles = 0;
  logic [24:0] pushQ[$];
  int pushCyc[$];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (pcd.busy) busyCycles <= busyCycles + 1;
    if (pcd.pendingWriteQueueWriteRequest) begin
      pushQ.push_back(pcd.pendingWriteQueueWriteBus);
      pushCyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clock);
    pcd.commandByte  = b;
    pcd.commandValid = 1'b1;
    while (!pcd.commandReady && n < 50) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (pcd.commandReady !== 1'b1) begin
      fails++;
      $display("FAIL send_byte_%02h ready=%b required 1", b, pcd.commandReady);
    end
    @(posedge clock);
    #1 pcd.commandValid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (pcd.busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (pcd.busy !== 1'b0) begin
      fails++;
      $display("FAIL wait_idle busy=%b required 0", pcd.busy);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset();
    pcd.commandByte = 8'h00;
    pcd.commandValid = 1'b0;
    pcd.pendingWriteQueueWriteFull = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    checks += 5;
    if (pcd.commandReady !== 1'b0) begin fails++; $display("FAIL rst_ready got=%b exp=0", pcd.commandReady); end
    if (pcd.pendingWriteQueueWriteRequest !== 1'b0) begin fails++; $display("FAIL rst_req got=%b exp=0", pcd.pendingWriteQueueWriteRequest); end
    if (pcd.pendingWriteQueueWriteBus !== 25'd0) begin fails++; $display("FAIL rst_bus got=%h exp=0", pcd.pendingWriteQueueWriteBus); end
    if (pcd.busy !== 1'b0) begin fails++; $display("FAIL rst_busy got=%b exp=0", pcd.busy); end
    if (pcd.badOpcode !== 1'b0) begin fails++; $display("FAIL rst_bad got=%b exp=0", pcd.badOpcode); end
    reset = 1'b1;
    #1 checks++;
    if (pcd.commandReady !== 1'b0) begin fails++; $display("FAIL rst_release_ready got=%b exp=0", pcd.commandReady); end
    @(posedge clock);
    #1 checks++;
    if (pcd.commandReady !== 1'b1) begin fails++; $display("FAIL rst_first_edge_ready got=%b exp=1", pcd.commandReady); end
  endtask

  task automatic test_write();
    logic [24:0] act;
    pushQ.delete();
    send_byte(8'h01); send_byte(8'h05); send_byte(8'h00);
    send_byte(8'h02); send_byte(8'h0A);
    send_byte(8'h03); send_byte(8'h7F);
    checks += 2;
    if (pcd.pendingWriteQueueWriteRequest !== 1'b1) begin fails++; $display("FAIL write_latency_req got=%b exp=1", pcd.pendingWriteQueueWriteRequest); end
    if (pcd.commandReady !== 1'b0) begin fails++; $display("FAIL write_ready got=%b exp=0", pcd.commandReady); end
    wait_idle();
    act = (pushQ.size() > 0) ? pushQ[0] : 'x;
    checks += 2;
    if (pushQ.size() != 1) begin fails++; $display("FAIL write_count got=%0d exp=1", pushQ.size()); end
    if (act !== {8'h0A, 9'h005, 8'h7F}) begin fails++; $display("FAIL write_bus got=%h exp=%h", act, {8'h0A, 9'h005, 8'h7F}); end
    send_byte(8'h03); send_byte(8'h22);
    wait_idle();
    act = (pushQ.size() > 1) ? pushQ[1] : 'x;
    checks += 2;
    if (pushQ.size() != 2) begin fails++; $display("FAIL write2_count got=%0d exp=2", pushQ.size()); end
    if (act !== {8'h0A, 9'h006, 8'h22}) begin fails++; $display("FAIL write2_cursor got=%h exp=%h", act, {8'h0A, 9'h006, 8'h22}); end
  endtask

  task automatic test_fill_wrap();
    logic [24:0] exp_q[3] = '{{8'hEF, 9'h13F, 8'h55}, {8'h00, 9'h000, 8'h55}, {8'h00, 9'h001, 8'h55}};
    logic [24:0] act;
    int bc0, span;
    pushQ.delete(); pushCyc.delete();
    send_byte(8'h01); send_byte(8'h3F); send_byte(8'h01);
    send_byte(8'h02); send_byte(8'hEF);
    bc0 = busyCycles;
    send_byte(8'h04); send_byte(8'h03); send_byte(8'h00); send_byte(8'h55);
    wait_idle();
    checks++;
    if (pushQ.size() != 3) begin fails++; $display("FAIL fill_count got=%0d exp=3", pushQ.size()); end
    for (int i = 0; i < 3; i++) begin
      act = (pushQ.size() > i) ? pushQ[i] : 'x;
      checks++;
      if (act !== exp_q[i]) begin fails++; $display("FAIL fill_bus%0d got=%h exp=%h", i, act, exp_q[i]); end
    end
    span = (pushCyc.size() == 3) ? pushCyc[2] - pushCyc[0] : -1;
    checks += 2;
    if (span != 2) begin fails++; $display("FAIL fill_consecutive span=%0d exp=2", span); end
    if (busyCycles - bc0 != 3) begin fails++; $display("FAIL fill_busy_cycles got=%0d exp=3", busyCycles - bc0); end
  endtask

  task automatic test_fill_full();
    logic [24:0] act;
    pushQ.delete();
    send_byte(8'h04); send_byte(8'h04); send_byte(8'h00); send_byte(8'h66);
    @(posedge clock);
    #1 pcd.pendingWriteQueueWriteFull = 1'b1;
    repeat (5) begin
      @(negedge clock);
      checks += 3;
      if (pcd.pendingWriteQueueWriteRequest !== 1'b0) begin fails++; $display("FAIL full_req got=%b exp=0", pcd.pendingWriteQueueWriteRequest); end
      if (pcd.commandReady !== 1'b0) begin fails++; $display("FAIL full_ready got=%b exp=0", pcd.commandReady); end
      if (pcd.busy !== 1'b1) begin fails++; $display("FAIL full_busy got=%b exp=1", pcd.busy); end
    end
    checks++;
    if (pushQ.size() != 1) begin fails++; $display("FAIL full_held_count got=%0d exp=1", pushQ.size()); end
    pcd.pendingWriteQueueWriteFull = 1'b0;
    wait_idle();
    checks += 2;
    if (pushQ.size() != 4) begin fails++; $display("FAIL full_count got=%0d exp=4", pushQ.size()); end
    if (pcd.commandReady !== 1'b1) begin fails++; $display("FAIL full_ready_after got=%b exp=1", pcd.commandReady); end
    for (int i = 0; i < 4; i++) begin
      act = (pushQ.size() > i) ? pushQ[i] : 'x;
      checks++;
      if (act !== {8'h00, 9'(2 + i), 8'h66}) begin fails++; $display("FAIL full_bus%0d got=%h exp=%h", i, act, {8'h00, 9'(2 + i), 8'h66}); end
    end
  endtask

  task automatic test_fill_zero();
    int bc0;
    pushQ.delete();
    bc0 = busyCycles;
    send_byte(8'h04); send_byte(8'h00); send_byte(8'h00); send_byte(8'hAA);
    checks += 2;
    if (pcd.busy !== 1'b0) begin fails++; $display("FAIL zero_busy got=%b exp=0", pcd.busy); end
    if (pcd.commandReady !== 1'b1) begin fails++; $display("FAIL zero_ready got=%b exp=1", pcd.commandReady); end
    repeat (3) @(negedge clock);
    checks += 2;
    if (pushQ.size() != 0) begin fails++; $display("FAIL zero_count got=%0d exp=0", pushQ.size()); end
    if (busyCycles != bc0) begin fails++; $display("FAIL zero_busy_cycles got=%0d exp=0", busyCycles - bc0); end
  endtask

  task automatic test_bad_opcode();
    logic [24:0] act;
    checks++;
    if (pcd.badOpcode !== 1'b0) begin fails++; $display("FAIL bad_before got=%b exp=0", pcd.badOpcode); end
    send_byte(8'h9C);
    checks += 2;
    if (pcd.badOpcode !== 1'b1) begin fails++; $display("FAIL bad_set got=%b exp=1", pcd.badOpcode); end
    if (pcd.commandReady !== 1'b1) begin fails++; $display("FAIL bad_ready got=%b exp=1", pcd.commandReady); end
    pushQ.delete();
    send_byte(8'h00);
    send_byte(8'h03); send_byte(8'h11);
    wait_idle();
    act = (pushQ.size() > 0) ? pushQ[0] : 'x;
    checks += 3;
    if (pushQ.size() != 1) begin fails++; $display("FAIL bad_write_count got=%0d exp=1", pushQ.size()); end
    if (act !== {8'h00, 9'h006, 8'h11}) begin fails++; $display("FAIL bad_write_bus got=%h exp=%h", act, {8'h00, 9'h006, 8'h11}); end
    if (pcd.badOpcode !== 1'b1) begin fails++; $display("FAIL bad_sticky got=%b exp=1", pcd.badOpcode); end
  endtask

  task automatic test_clip();
    logic [24:0] act;
    int n;
    pushQ.delete();
    send_byte(8'h01); send_byte(8'h90); send_byte(8'h01);
    send_byte(8'h02); send_byte(8'h05);
    send_byte(8'h03); send_byte(8'h33);
    wait_idle();
`ifdef PIXEL_COMMAND_CLIP_EN
    n = 0;
`else
    n = 1;
    act = (pushQ.size() > 0) ? pushQ[0] : 'x;
    checks++;
    if (act !== {8'h05, 9'h190, 8'h33}) begin fails++; $display("FAIL clip_bus got=%h exp=%h", act, {8'h05, 9'h190, 8'h33}); end
`endif
    checks++;
    if (pushQ.size() != n) begin fails++; $display("FAIL clip_count got=%0d exp=%0d", pushQ.size(), n); end
    send_byte(8'h03); send_byte(8'h44);
    wait_idle();
    act = (pushQ.size() == n + 1) ? pushQ[n] : 'x;
    checks++;
    if (act !== {8'h06, 9'h000, 8'h44}) begin fails++; $display("FAIL clip_wrap_bus got=%h exp=%h", act, {8'h06, 9'h000, 8'h44}); end
  endtask

  task automatic test_reset_mid_fill();
    pushQ.delete();
    send_byte(8'h04); send_byte(8'h0A); send_byte(8'h00); send_byte(8'h77);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    #1 checks += 3;
    if (pcd.pendingWriteQueueWriteRequest !== 1'b0) begin fails++; $display("FAIL midrst_req got=%b exp=0", pcd.pendingWriteQueueWriteRequest); end
    if (pcd.busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got=%b exp=0", pcd.busy); end
    if (pcd.commandReady !== 1'b0) begin fails++; $display("FAIL midrst_ready got=%b exp=0", pcd.commandReady); end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 checks++;
    if (pcd.commandReady !== 1'b1) begin fails++; $display("FAIL midrst_ready_after got=%b exp=1", pcd.commandReady); end
    repeat (4) @(negedge clock);
    checks += 2;
    if (pushQ.size() != 2) begin fails++; $display("FAIL midrst_count got=%0d exp=2", pushQ.size()); end
    if (pcd.busy !== 1'b0) begin fails++; $display("FAIL midrst_busy_after got=%b exp=0", pcd.busy); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_fill_wrap();
    test_fill_full();
    test_fill_zero();
    test_bad_opcode();
    test_clip();
    test_reset_mid_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
